// File: rtl/weight_column_encoder_pkg.sv
// Shared constants and FSM encoding for the bit-serial weight column encoder.
package weight_column_encoder_pkg;
  localparam int SEL_WIDTH       = 3;
  localparam int WINDOW_SIZE     = 5;
  localparam int MUX_PER_GROUP   = 4;
  localparam int LANES_PER_GROUP = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/weight_column_encoder_group_col_encoder.sv
// Encodes one 8-lane bit column into four windowed mux selects; purely combinational.
module group_col_encoder
  import weight_column_encoder_pkg::*;
(
  input  logic [LANES_PER_GROUP-1:0]                i_col,
  output logic [MUX_PER_GROUP-1:0][SEL_WIDTH-1:0]   o_sel,
  output logic [MUX_PER_GROUP-1:0]                  o_val,
  output logic                                      o_skip_zero
);
  logic [3:0]                 w_ones;
  logic [LANES_PER_GROUP-1:0] w_targets;

  always_comb begin
    w_ones = '0;
    for (int k = 0; k < LANES_PER_GROUP; k++) begin
      w_ones = w_ones + 4'(i_col[k]);
    end
  end

  // Dense columns are cheaper to express as "group sum minus the zero lanes".
  assign o_skip_zero = (w_ones <= 4'd4);
  assign w_targets   = o_skip_zero ? i_col : ~i_col;

  always_comb begin : mux_assign
    logic [2:0] w_tgt_cnt;
    logic [1:0] w_mux;
    o_sel     = '0;
    o_val     = '0;
    w_tgt_cnt = '0;
    w_mux     = '0;
    for (int k = 0; k < LANES_PER_GROUP; k++) begin
      if (w_targets[k]) begin
        // Target t lands on mux max(t, e_t - 4): the earliest mux whose window reaches lane e_t.
        if (k >= WINDOW_SIZE - 1 && (k - (WINDOW_SIZE - 1)) > int'(w_tgt_cnt)) begin
          w_mux = 2'(k - (WINDOW_SIZE - 1));
        end else begin
          w_mux = w_tgt_cnt[1:0];
        end
        o_sel[w_mux] = SEL_WIDTH'(k - int'(w_mux));
        o_val[w_mux] = 1'b1;
        w_tgt_cnt    = w_tgt_cnt + 3'd1;
      end
    end
  end
endmodule

// File: rtl/weight_column_encoder.sv
// Scans a vector of signed weights MSB-first, skipping all-zero bit columns, and
// emits one MAC control word per non-zero column over a valid/ready stream.
module weight_column_encoder
  import weight_column_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        w_valid,
  output logic                                        w_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]       weight,
  output logic                                        ctrl_valid,
  input  logic                                        ctrl_ready,
  output logic [VEC_LENGTH/2-1:0][SEL_WIDTH-1:0]      act_sel,
  output logic [VEC_LENGTH/2-1:0]                     act_val,
  output logic [VEC_LENGTH/8-1:0]                     is_skip_zero,
  output logic [2:0]                                  column_idx,
  output logic                                        is_msb,
  output logic                                        load_accum,
  output logic                                        ctrl_last,
  output logic [2:0]                                  mul_const,
  output logic                                        is_shift_mul
);
  localparam int GROUPS = VEC_LENGTH / LANES_PER_GROUP;

  state_t                                  r_state, w_state_next;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   r_weight, w_weight_next;
  logic [DATA_WIDTH-1:0]                   r_mask, w_mask_next;
  logic                                    r_first, w_first_next;
  logic [DATA_WIDTH-1:0]                   w_in_mask, w_rest_mask;
  logic [2:0]                              w_col;
  logic                                    w_last, w_hs, w_accept;

  always_comb begin
    w_in_mask = '0;
    for (int k = 0; k < VEC_LENGTH; k++) begin
      w_in_mask = w_in_mask | weight[k];
    end
  end

  // Highest remaining column; an empty mask yields column 0 for the all-zero word.
  always_comb begin
    w_col = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      if (r_mask[b]) w_col = 3'(b);
    end
  end

  assign w_rest_mask = r_mask & ~(DATA_WIDTH'(1) << w_col);
  assign w_last      = (w_rest_mask == '0);
  assign ctrl_valid  = (r_state == ST_RUN);
  assign w_hs        = ctrl_valid && ctrl_ready;
  assign w_ready     = !ctrl_valid || (w_hs && w_last);
  assign w_accept    = w_valid && w_ready;

  always_comb begin
    w_state_next  = r_state;
    w_weight_next = r_weight;
    w_mask_next   = r_mask;
    w_first_next  = r_first;
    case (r_state)
      ST_IDLE: ;
      ST_RUN: begin
        if (w_hs) begin
          w_mask_next  = w_rest_mask;
          w_first_next = 1'b0;
          if (w_last) w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_accept) begin
      w_state_next  = ST_RUN;
      w_weight_next = weight;
      w_mask_next   = w_in_mask;
      w_first_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_weight <= '0;
      r_mask   <= '0;
      r_first  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_weight <= w_weight_next;
      r_mask   <= w_mask_next;
      r_first  <= w_first_next;
    end
  end

  generate
    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_group
      logic [LANES_PER_GROUP-1:0] w_slice;
      always_comb begin
        for (int k = 0; k < LANES_PER_GROUP; k++) begin
          w_slice[k] = r_weight[gi*LANES_PER_GROUP + k][w_col];
        end
      end
      group_col_encoder u_enc (
        .i_col       (w_slice),
        .o_sel       (act_sel[gi*MUX_PER_GROUP +: MUX_PER_GROUP]),
        .o_val       (act_val[gi*MUX_PER_GROUP +: MUX_PER_GROUP]),
        .o_skip_zero (is_skip_zero[gi])
      );
    end
  endgenerate

  assign column_idx   = w_col;
  assign is_msb       = (w_col == 3'(DATA_WIDTH - 1));
  assign load_accum   = ctrl_valid && r_first;
  assign ctrl_last    = ctrl_valid && w_last;
  assign mul_const    = '0;
  assign is_shift_mul = 1'b0;
endmodule

// File: tb/tb_weight_column_encoder.sv
// Randomised bench for weight_column_encoder against a queue-based word model.
module tb_weight_column_encoder;
  localparam int DW = 8;
  localparam int VL = 16;
  localparam int NM = VL / 2;
  localparam int NG = VL / 8;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   w_valid = 1'b0;
  logic                   ctrl_ready = 1'b0;
  logic [VL-1:0][DW-1:0]  weight = '0;
  logic                   w_ready, ctrl_valid, is_msb, load_accum, ctrl_last, is_shift_mul;
  logic [NM-1:0][2:0]     act_sel;
  logic [NM-1:0]          act_val;
  logic [NG-1:0]          is_skip_zero;
  logic [2:0]             column_idx, mul_const;

  weight_column_encoder #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
    .clk(clk), .reset_n(reset_n), .w_valid(w_valid), .w_ready(w_ready), .weight(weight),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .act_sel(act_sel), .act_val(act_val),
    .is_skip_zero(is_skip_zero), .column_idx(column_idx), .is_msb(is_msb),
    .load_accum(load_accum), .ctrl_last(ctrl_last), .mul_const(mul_const),
    .is_shift_mul(is_shift_mul)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      col;
    logic [NM*3-1:0] sel;
    logic [NM-1:0]   val;
    logic [NG-1:0]   skip;
    logic            load;
    logic            last;
  } word_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  bit    just_reset = 1'b0;
  int    rdy_mode = 0;
  int    vec_id = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoding written directly from the column/target/window rules.
  function automatic word_t encode(input logic [VL-1:0] colv, input int b, input bit first,
                                   input bit last);
    word_t r;
    int    tg[$];
    int    ones, e, j, m;
    bit    sz;
    r.col = 3'(b); r.sel = '0; r.val = '0; r.skip = '0; r.load = first; r.last = last;
    for (int g = 0; g < NG; g++) begin
      ones = 0;
      tg.delete();
      for (int k = 0; k < 8; k++) ones += int'(colv[8*g+k]);
      sz = (ones <= 4);
      r.skip[g] = sz;
      for (int k = 0; k < 8; k++) if (colv[8*g+k] == sz) tg.push_back(k);
      for (int t = 0; t < tg.size(); t++) begin
        e = tg[t];
        j = (e - 4 > t) ? e - 4 : t;
        m = 4*g + j;
        r.sel[3*m +: 3] = 3'(e - j);
        r.val[m] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [VL-1:0] column_of(input logic [VL-1:0][DW-1:0] w, input int b);
    logic [VL-1:0] c;
    for (int k = 0; k < VL; k++) c[k] = w[k][b];
    return c;
  endfunction

  function automatic void model_push(input logic [VL-1:0][DW-1:0] w);
    int n = 0;
    int idx = 0;
    for (int b = 0; b < DW; b++) if (column_of(w, b) != '0) n++;
    if (n == 0) begin
      exp_q.push_back(encode('0, 0, 1'b1, 1'b1));
    end else begin
      for (int b = DW-1; b >= 0; b--) begin
        if (column_of(w, b) != '0) begin
          exp_q.push_back(encode(column_of(w, b), b, idx == 0, idx == n-1));
          idx++;
        end
      end
    end
  endfunction

  // Monitor: compares every cycle on the falling edge, then advances the model.
  initial begin
    bit exp_v, exp_wr;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        just_reset = 1'b1;
      end else begin
        exp_v  = (exp_q.size() != 0);
        exp_wr = !exp_v || (ctrl_ready && exp_q[0].last);
        check("ctrl_valid", 32'(ctrl_valid), 32'(exp_v));
        check("w_ready", 32'(w_ready), 32'(exp_wr));
        check("mul_const", 32'(mul_const), 32'd0);
        check("is_shift_mul", 32'(is_shift_mul), 32'd0);
        if (just_reset) begin
          check("rst_act_sel", 32'(act_sel), 32'd0);
          check("rst_act_val", 32'(act_val), 32'd0);
          check("rst_skip_zero", 32'(is_skip_zero), 32'h3);
          check("rst_column", 32'(column_idx), 32'd0);
          check("rst_ctl", 32'({is_msb, load_accum, ctrl_last}), 32'd0);
          just_reset = 1'b0;
        end
        if (exp_v) begin
          check("column_idx", 32'(column_idx), 32'(exp_q[0].col));
          check("act_sel", 32'(act_sel), 32'(exp_q[0].sel));
          check("act_val", 32'(act_val), 32'(exp_q[0].val));
          check("is_skip_zero", 32'(is_skip_zero), 32'(exp_q[0].skip));
          check("is_msb", 32'(is_msb), 32'(exp_q[0].col == 3'd7));
          check("load_accum", 32'(load_accum), 32'(exp_q[0].load));
          check("ctrl_last", 32'(ctrl_last), 32'(exp_q[0].last));
        end
        if (exp_v && ctrl_ready) void'(exp_q.pop_front());
        if (w_valid && exp_wr) begin
          $display("vec %0d accepted at t=%0t", vec_id, $time);
          vec_id++;
          model_push(weight);
        end
      end
    end
  end

  initial begin
    bit tog = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: ctrl_ready = 1'b1;
        1: ctrl_ready = ($urandom_range(0, 3) != 0);
        2: ctrl_ready = 1'b0;
        default: begin ctrl_ready = tog; tog = ~tog; end
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [VL-1:0][DW-1:0] w, input bit hold);
    bit acc = 1'b0;
    int cyc = 0;
    weight  = w;
    w_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = w_ready;
      step();
      cyc++;
    end while (!acc && cyc < 500);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    if (!hold) w_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin step(); cyc++; end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [DW-1:0] rnd_lane(input int d);
    logic [DW-1:0] a, b, c;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    case (d)
      0: return '0;
      1: return a & b & c;
      2: return a;
      3: return a | b;
      default: return a | b | c;
    endcase
  endfunction

  initial begin
    logic [VL-1:0][DW-1:0] w;
    int d;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    w = '0;                                   // all-zero vector
    send(w, 1'b0); drain();
    w = '0; w[6] = 8'h01; w[7] = 8'h01;       // sparse lanes 6,7
    send(w, 1'b0); drain();
    w = '0; for (int k = 0; k < 6; k++) w[k] = 8'h80;
    send(w, 1'b0); drain();
    w = '0; w[0] = 8'h81;
    send(w, 1'b0); drain();

    rdy_mode = 3;                             // toggling ready, back-to-back vectors
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < VL; k++) w[k] = rnd_lane(2);
      send(w, v != 2);
    end
    drain();

    rdy_mode = 0;                             // reset mid-vector
    w = '0; w[3] = 8'b0100_1010;
    send(w, 1'b0);
    rdy_mode = 2;
    repeat (2) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    rdy_mode = 0;
    repeat (6) step();

    rdy_mode = 1;
    for (int v = 0; v < 200; v++) begin
      d = $urandom_range(0, 4);
      for (int k = 0; k < VL; k++) w[k] = rnd_lane(($urandom_range(0, 7) == 0) ? 0 : d);
      send(w, $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 5) == 0) begin
        w_valid = 1'b0;
        repeat ($urandom_range(1, 4)) step();
      end
    end
    w_valid = 1'b0;
    rdy_mode = 0;
    drain();
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/weight_column_encoder.md
# weight_column_encoder

Streams bit-serial control words to the 16-lane vertical MAC unit. Each accepted vector of 16 signed 8-bit weights is scanned bit-column by bit-column, from MSB (column 7) to LSB. All-zero columns are skipped. Every remaining column is converted into the activation-mux selects, valid flags, skip-zero mode, column index and accumulator controls the MAC consumes, one column per cycle, over a valid/ready stream.

## Interface
- DATA_WIDTH, 8: weight width, which is also the number of bit columns.
- VEC_LENGTH, 16: lanes per vector. The vector splits into VEC_LENGTH/8 groups of 8 lanes, with 4 muxes per group.
- SEL_WIDTH, 3: mux select width. Select range is 0..4.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- w_valid  in  1  weight vector valid.
- w_ready  out  1  encoder can accept a vector.
- weight  in  DATA_WIDTH x VEC_LENGTH  signed weights; lane k is weight[k].
- ctrl_valid  out  1  control word valid.
- ctrl_ready  in  1  MAC consumes the word.
- act_sel  out  SEL_WIDTH x VEC_LENGTH/2  mux select per mux.
- act_val  out  1 x VEC_LENGTH/2  mux valid.
- is_skip_zero  out  1 x VEC_LENGTH/8  1 = sum of selected lanes; 0 = group sum minus selected lanes.
- column_idx  out  3  bit column of this word.
- is_msb  out  1  column_idx == DATA_WIDTH-1.
- load_accum  out  1  first word of a vector.
- ctrl_last  out  1  final word of a vector.
- mul_const  out  3  tied 0 (reserved for the constant-multiplier path).
- is_shift_mul  out  1  tied 0.

## Operation
- FSM states:
  - IDLE: w_ready=1, ctrl_valid=0. On w_valid, register weight, compute col_mask[b] = OR of bit b over all lanes, then go to RUN.
  - RUN: ctrl_valid=1. The current column is the highest set bit of the remaining mask. On a ctrl_ready handshake, clear that bit. If it was the last set bit, go to IDLE, unless back-to-back acceptance applies.
- All-zero vector (col_mask == 0): emit exactly one word with column_idx=0, every act_val=0, is_skip_zero all 1, load_accum=1, ctrl_last=1.
- Group encoding for column b, group g, with m[k] = weight[8g+k][b]:
  - n1 = popcount(m).
  - If n1 ≤ 4: is_skip_zero[g]=1 and the targets are the lanes with m=1.
  - Otherwise: is_skip_zero[g]=0 and the targets are the lanes with m=0 (at most 3).
- Mux assignment: take the targets sorted ascending, e_0 < … < e_{n-1}. Target t is driven by mux j = max(t, e_t−4), with act_sel = e_t−j and act_val=1. This mapping always fits the 5-lane windows, so no column ever needs a second pass. Unused muxes have act_val=0 and act_sel=0.
- Mux index seen by the MAC is 4g+j.
- load_accum=1 only on the first word of a vector. ctrl_last=1 only on the last.
- All control outputs are a pure function of the registered weight and the remaining mask. They are stable while ctrl_valid=1 and ctrl_ready=0.

## Timing
- Reset (reset_n=0 at a clk edge) forces state IDLE and clears the mask and weight register.
  - Output values under reset: w_ready=1, ctrl_valid=0, and every control output is 0, except is_skip_zero, which is all 1.
  - A reset mid-vector discards the vector. No word is emitted after the reset is released until a new handshake.
- Latency: a vector accepted at edge N gives its first word valid after edge N.
- Throughput: one word per cycle while ctrl_ready=1. A vector takes popcount(col_mask) cycles (minimum 1).
- Back-to-back acceptance: w_ready = IDLE || (ctrl_valid && ctrl_ready && ctrl_last). A vector accepted on the last-word handshake is emitted starting the next cycle, with no bubble.
- If ctrl_ready is held low, the word is held indefinitely and no new vector is accepted.
- w_valid in RUN without the last-word handshake is ignored; the upstream must hold it.

## Structure
- Shared package: SEL_WIDTH, mux window size 5, muxes per group 4, lanes per group 8, and the FSM state enum.
- Sub-module group_col_encoder: 8-bit column slice in; 4 selects, 4 valids and is_skip_zero out; purely combinational. Instantiate it VEC_LENGTH/8 times.

## Test plan
1. All weights = 0 → one word: column_idx=0, load_accum=1, ctrl_last=1, act_val all 0, is_skip_zero=11.
2. Lanes 6 and 7 = 8'h01, all others 0 → one word, column_idx=0:
   - mux 2: sel=4, val=1; mux 3: sel=4, val=1.
   - mux 0, mux 1 and all group-1 muxes: val=0.
   - is_skip_zero=11.
3. Lanes 0–5 = 8'h80, lanes 6 and 7 = 0 → one word, column_idx=7, is_msb=1, is_skip_zero[0]=0, zeros at lanes 6 and 7 encoded as mux 2 sel=4 and mux 3 sel=4.
4. Lane 0 = 8'h81 with ctrl_ready=1 → two words, columns 7 then 0. load_accum is set on the first word only; ctrl_last on the second only.
5. Back-to-back vectors with ctrl_ready toggling 1,0,1 → words are held stable while stalled, and the second vector's first word follows its predecessor's last word with no gap.
6. reset_n pulsed low while a 3-column vector is mid-stream → ctrl_valid=0 and w_ready=1 the next cycle, and the old vector never resumes.
